// File: rtl/car_status_ctrl.sv
// Driver-input front end: sync + debounce of buttons/brake, turn/hazard FSM, registered car_status.
// Optional LEFT/RIGHT auto-cancel timer is built when CAR_STATUS_AUTO_CANCEL_EN is defined.

module car_status_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;
endmodule

module car_status_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int AUTO_OFF_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_hazard,
  input  logic       sw_brake,
  output logic [3:0] car_status,
  output logic       status_chg
);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (AUTO_OFF_CYCLES < 2) begin : g_chk_ao
    $error("AUTO_OFF_CYCLES must be at least 2");
  end

  // Input order: [0] left, [1] right, [2] hazard, [3] brake
  logic [3:0] w_raw, w_deb;
  assign w_raw = {sw_brake, btn_hazard, btn_right, btn_left};

  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    car_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .i_raw (w_raw[gi]),
      .o_deb (w_deb[gi])
    );
  end

  logic [2:0] r_deb_d, w_press;
  logic       r_brake_d;
  state_t     r_state, r_saved, w_next;
  logic       w_save;
  logic [3:0] r_status, w_status;
  logic       r_chg;

  assign w_press = w_deb[2:0] & ~r_deb_d;

`ifdef CAR_STATUS_AUTO_CANCEL_EN
  localparam int TW = $clog2(AUTO_OFF_CYCLES);
  localparam logic [TW-1:0] TMR_MAX = TW'(AUTO_OFF_CYCLES - 1);
  logic [TW-1:0] r_timer;
  logic          w_expired;
  assign w_expired = (r_state == LEFT || r_state == RIGHT) && (r_timer == TMR_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_timer <= '0;
    else if (w_next != r_state || !(r_state == LEFT || r_state == RIGHT))
      r_timer <= '0;
    else
      r_timer <= r_timer + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_d   <= '0;
      r_brake_d <= 1'b0;
      r_state   <= IDLE;
      r_saved   <= IDLE;
    end else begin
      r_deb_d   <= w_deb[2:0];
      // Brake waits one extra cycle so it lines up with the FSM-path latency
      r_brake_d <= w_deb[3];
      r_state   <= w_next;
      if (w_save) r_saved <= r_state;
    end
  end

  always_comb begin
    w_next = r_state;
    w_save = 1'b0;
    if (w_press[2]) begin
      if (r_state == HAZARD) begin
        w_next = r_saved;
      end else begin
        w_next = HAZARD;
        w_save = 1'b1;
      end
    end else if (r_state != HAZARD && !(w_press[0] && w_press[1])) begin
      case (r_state)
        IDLE:  if (w_press[0]) w_next = LEFT;  else if (w_press[1]) w_next = RIGHT;
        LEFT:  if (w_press[0]) w_next = IDLE;  else if (w_press[1]) w_next = RIGHT;
        RIGHT: if (w_press[1]) w_next = IDLE;  else if (w_press[0]) w_next = LEFT;
        default: w_next = r_state;
      endcase
    end
`ifdef CAR_STATUS_AUTO_CANCEL_EN
    // Any press-driven transition wins over expiry
    if (w_next == r_state && w_expired) w_next = IDLE;
`endif
  end

  assign w_status = {r_brake_d, r_state == HAZARD, r_state == RIGHT, r_state == LEFT};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= 4'b0000;
      r_chg    <= 1'b0;
    end else begin
      r_status <= w_status;
      r_chg    <= (w_status != r_status);
    end
  end

  assign car_status = r_status;
  assign status_chg = r_chg;
endmodule
